// File: rtl/inst_decode_stage.sv
// Registered instruction decode stage: slices each instruction into fields, adds the
// extended immediate, array select and illegal flag, and buffers bundles in a 2-entry skid.
module inst_decode_stage #(
  parameter int                        INST_WIDTH    = 16,
  parameter int                        OPCODE_W      = 4,
  parameter int                        REG_W         = 4,
  parameter int                        IMM_SHORT_W   = 4,
  parameter int                        IMM_LONG_W    = 8,
  parameter int                        DATA_W        = 16,
  parameter int                        ARRAY_ID_W    = 2,
  parameter bit                        SIGN_EXT_IMM  = 1'b1,
  parameter logic [2**OPCODE_W-1:0]    LEGAL_OPCODES = 16'h0FFF,
  parameter int                        CNT_W         = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INST_WIDTH-1:0]      instruction,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OPCODE_W-1:0]        opcode,
  output logic [REG_W-1:0]           target_reg,
  output logic [REG_W-1:0]           address_reg,
  output logic [IMM_SHORT_W-1:0]     imm_short,
  output logic [IMM_LONG_W-1:0]      imm_long,
  output logic [DATA_W-1:0]          imm_ext,
  output logic [ARRAY_ID_W-1:0]      array_id,
  output logic [2**ARRAY_ID_W-1:0]   array_sel,
  output logic                       illegal,
  output logic [CNT_W-1:0]           decode_count
);

  localparam int SEL_W = 2**ARRAY_ID_W;

  if (DATA_W < IMM_LONG_W) begin : g_chk_data_w
    $error("inst_decode_stage: DATA_W must be at least IMM_LONG_W");
  end
  if (OPCODE_W + 2*REG_W > INST_WIDTH) begin : g_chk_fields
    $error("inst_decode_stage: opcode and register fields exceed INST_WIDTH");
  end
  if (ARRAY_ID_W > IMM_SHORT_W) begin : g_chk_array_id
    $error("inst_decode_stage: ARRAY_ID_W must not exceed IMM_SHORT_W");
  end

  typedef struct packed {
    logic [OPCODE_W-1:0]    opcode;
    logic [REG_W-1:0]       target_reg;
    logic [REG_W-1:0]       address_reg;
    logic [IMM_SHORT_W-1:0] imm_short;
    logic [IMM_LONG_W-1:0]  imm_long;
    logic [DATA_W-1:0]      imm_ext;
    logic [ARRAY_ID_W-1:0]  array_id;
    logic [SEL_W-1:0]       array_sel;
    logic                   illegal;
  } bundle_t;

  bundle_t          dec;
  bundle_t          or_q, or_d;
  bundle_t          sr_q, sr_d;
  logic             or_valid_q, or_valid_d;
  logic             sr_valid_q, sr_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_xfer;
  logic             out_xfer;

  always_comb begin
    // NOTE: every field gets a default first so no path through this block infers a latch.
    dec             = '0;
    dec.opcode      = instruction[INST_WIDTH-1 -: OPCODE_W];
    dec.target_reg  = instruction[INST_WIDTH-OPCODE_W-1 -: REG_W];
    dec.address_reg = instruction[INST_WIDTH-OPCODE_W-REG_W-1 -: REG_W];
    dec.imm_short   = instruction[IMM_SHORT_W-1:0];
    dec.imm_long    = instruction[IMM_LONG_W-1:0];
    if (SIGN_EXT_IMM) dec.imm_ext = DATA_W'($signed(dec.imm_long));
    else              dec.imm_ext = DATA_W'(dec.imm_long);
    dec.array_id    = dec.imm_short[IMM_SHORT_W-1 -: ARRAY_ID_W];
    dec.array_sel   = SEL_W'(1) << dec.array_id;
    dec.illegal     = ~LEGAL_OPCODES[dec.opcode];
  end

  // in_ready depends only on registered skid state and rst, never on out_ready.
  assign in_ready = ~sr_valid_q & ~rst;
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = or_valid_q & out_ready;

  always_comb begin
    or_d       = or_q;
    sr_d       = sr_q;
    or_valid_d = or_valid_q;
    sr_valid_d = sr_valid_q;
    cnt_d      = cnt_q + CNT_W'(out_xfer);

    if (!or_valid_q || out_xfer) begin
      // Output register is free this edge: the skid entry always goes first to keep order.
      if (sr_valid_q) begin
        or_d       = sr_q;
        or_valid_d = 1'b1;
        sr_valid_d = 1'b0;
      end else if (in_xfer) begin
        or_d       = dec;
        or_valid_d = 1'b1;
      end else begin
        or_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      sr_d       = dec;
      sr_valid_d = 1'b1;
    end

    if (flush) begin
      or_d       = or_q;
      sr_d       = sr_q;
      or_valid_d = 1'b0;
      sr_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the bundle registers are reset too, because the data outputs must read zero after reset.
    if (rst) begin
      or_q       <= '0;
      sr_q       <= '0;
      or_valid_q <= 1'b0;
      sr_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      or_q       <= or_d;
      sr_q       <= sr_d;
      or_valid_q <= or_valid_d;
      sr_valid_q <= sr_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid    = or_valid_q;
  assign opcode       = or_q.opcode;
  assign target_reg   = or_q.target_reg;
  assign address_reg  = or_q.address_reg;
  assign imm_short    = or_q.imm_short;
  assign imm_long     = or_q.imm_long;
  assign imm_ext      = or_q.imm_ext;
  assign array_id     = or_q.array_id;
  assign array_sel    = or_q.array_sel;
  assign illegal      = or_q.illegal;
  assign decode_count = cnt_q;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Bench for inst_decode_stage: directed scenarios plus random traffic against a queue-based
// model of a 2-deep in-order buffer, on a default instance and a zero-extend/4-bit-counter one.
module tb_inst_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [15:0] instruction;

  logic        in_ready, out_valid, illegal;
  logic [3:0]  opcode, target_reg, address_reg, imm_short, array_sel;
  logic [7:0]  imm_long;
  logic [15:0] imm_ext, decode_count;
  logic [1:0]  array_id;

  logic        z_in_ready, z_out_valid, z_illegal;
  logic [3:0]  z_opcode, z_target_reg, z_address_reg, z_imm_short, z_array_sel;
  logic [7:0]  z_imm_long;
  logic [15:0] z_imm_ext;
  logic [3:0]  z_decode_count;
  logic [1:0]  z_array_id;

  logic [46:0] dut_bundle, z_bundle;

  int          n_tests = 0;
  int          n_fail  = 0;

  logic [15:0] mq[$];
  int unsigned m_cnt = 0;

  always #5 clk = ~clk;

  inst_decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .target_reg(target_reg), .address_reg(address_reg),
    .imm_short(imm_short), .imm_long(imm_long), .imm_ext(imm_ext), .array_id(array_id),
    .array_sel(array_sel), .illegal(illegal), .decode_count(decode_count)
  );

  inst_decode_stage #(.SIGN_EXT_IMM(1'b0), .CNT_W(4)) dut_z (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(z_in_ready),
    .instruction(instruction), .out_valid(z_out_valid), .out_ready(out_ready),
    .opcode(z_opcode), .target_reg(z_target_reg), .address_reg(z_address_reg),
    .imm_short(z_imm_short), .imm_long(z_imm_long), .imm_ext(z_imm_ext), .array_id(z_array_id),
    .array_sel(z_array_sel), .illegal(z_illegal), .decode_count(z_decode_count)
  );

  assign dut_bundle = {opcode, target_reg, address_reg, imm_short, imm_long, imm_ext,
                       array_id, array_sel, illegal};
  assign z_bundle   = {z_opcode, z_target_reg, z_address_reg, z_imm_short, z_imm_long, z_imm_ext,
                       z_array_id, z_array_sel, z_illegal};

  // Expected decoded bundle from plain arithmetic on the instruction value.
  function automatic logic [46:0] exp_bundle(input logic [15:0] i, input bit sext);
    int unsigned v, op, tr, ar, is, il, ie, aid, sel;
    v   = i;
    op  = v / 4096;
    tr  = (v / 256) % 16;
    ar  = (v / 16) % 16;
    is  = v % 16;
    il  = v % 256;
    ie  = (sext && il >= 128) ? il + 65536 - 256 : il;
    aid = is / 4;
    sel = 1 << aid;
    return {op[3:0], tr[3:0], ar[3:0], is[3:0], il[7:0], ie[15:0], aid[1:0], sel[3:0],
            (op >= 12) ? 1'b1 : 1'b0};
  endfunction

  // Advance one clock and update the model: a 2-deep FIFO, count of output transfers.
  task automatic tick();
    bit ix, ox;
    ix = in_valid && !rst && (mq.size() < 2);
    ox = (mq.size() > 0) && out_ready;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_cnt = 0;
    end else begin
      if (ox) begin
        void'(mq.pop_front());
        m_cnt++;
      end
      if (flush) mq.delete();
      else if (ix) mq.push_back(instruction);
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instruction = 16'h0;
    tick();
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_tests++; if (dut_bundle !== 47'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", dut_bundle); end
    n_tests++; if (decode_count !== 16'h0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", decode_count); end
    rst = 1'b0;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    instruction = 16'h3A5C; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    n_tests++;
    if ({opcode, target_reg, address_reg, imm_short, imm_long} !== 24'h3A5C5C) begin
      n_fail++; $display("FAIL basic_fields: got %h %h %h %h %h want 3 a 5 c 5c",
                         opcode, target_reg, address_reg, imm_short, imm_long);
    end
    n_tests++; if (imm_ext !== 16'h005C) begin n_fail++; $display("FAIL basic_imm_ext: got %h want 005c", imm_ext); end
    n_tests++;
    if ({array_id, array_sel, illegal} !== {2'd3, 4'b1000, 1'b0}) begin
      n_fail++; $display("FAIL basic_array: got id=%0d sel=%b ill=%b want id=3 sel=1000 ill=0",
                         array_id, array_sel, illegal);
    end
    n_tests++; if (dut_bundle !== exp_bundle(16'h3A5C, 1'b1)) begin n_fail++; $display("FAIL basic_model: got %h want %h", dut_bundle, exp_bundle(16'h3A5C, 1'b1)); end
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_ext_illegal();
    instruction = 16'hF2F4; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_tests++; if (imm_ext !== 16'hFFF4) begin n_fail++; $display("FAIL ext_sign: got %h want fff4", imm_ext); end
    n_tests++; if (z_imm_ext !== 16'h00F4) begin n_fail++; $display("FAIL ext_zero: got %h want 00f4", z_imm_ext); end
    n_tests++;
    if ({array_id, array_sel} !== {2'd1, 4'b0010}) begin
      n_fail++; $display("FAIL ext_array: got id=%0d sel=%b want id=1 sel=0010", array_id, array_sel);
    end
    n_tests++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL ext_illegal: got %b want 1", illegal); end
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; instruction = 16'h1001;
    tick();
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready1: got %b want 1", in_ready); end
    instruction = 16'h1002;
    tick();
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready2: got %b want 0", in_ready); end
    instruction = 16'h1003;
    tick();
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready3: got %b want 0", in_ready); end
    n_tests++; if (out_valid !== 1'b1 || imm_long !== 8'h01) begin n_fail++; $display("FAIL bp_hold: got v=%b imm=%h want v=1 imm=01", out_valid, imm_long); end
    out_ready = 1'b1;
    tick();
    n_tests++; if (out_valid !== 1'b1 || imm_long !== 8'h02) begin n_fail++; $display("FAIL bp_second: got v=%b imm=%h want v=1 imm=02", out_valid, imm_long); end
    tick();
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b1 || imm_long !== 8'h03) begin n_fail++; $display("FAIL bp_third: got v=%b imm=%h want v=1 imm=03", out_valid, imm_long); end
    tick();
    n_tests++; if (decode_count !== 16'd3) begin n_fail++; $display("FAIL bp_count: got %0d want 3", decode_count); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    int unsigned c0;
    out_ready = 1'b0; in_valid = 1'b1; instruction = 16'h4444;
    tick();
    instruction = 16'h5555;
    tick();
    flush = 1'b1; instruction = 16'h6666; c0 = m_cnt;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_full_valid: got %b want 0", out_valid); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_full_ready: got %b want 1", in_ready); end
    tick();
    n_tests++; if (out_valid !== 1'b0 || decode_count !== 16'(c0)) begin n_fail++; $display("FAIL flush_full_after: got v=%b cnt=%0d want v=0 cnt=%0d", out_valid, decode_count, c0); end
    out_ready = 1'b0; in_valid = 1'b1; instruction = 16'h2222;
    tick();
    flush = 1'b1; out_ready = 1'b1; instruction = 16'h3333; c0 = m_cnt;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_tests++; if (decode_count !== 16'(c0 + 1)) begin n_fail++; $display("FAIL flush_drain_count: got %0d want %0d", decode_count, c0 + 1); end
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_discard_input: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 20 && m_cnt < 5; k++) begin
      instruction = 16'(16'h0100 + k);
      tick();
    end
    out_ready = 1'b0;
    for (int k = 0; k < 4 && mq.size() < 2; k++) tick();
    n_tests++; if (decode_count !== 16'd5 || in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_setup: got cnt=%0d rdy=%b want cnt=5 rdy=0", decode_count, in_ready); end
    rst = 1'b1;
    tick();
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || decode_count !== 16'd0) begin n_fail++; $display("FAIL rmid_reset: got v=%b rdy=%b cnt=%0d want 0 0 0", out_valid, in_ready, decode_count); end
    tick();
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_hold_ready: got %b want 0", in_ready); end
    rst = 1'b0; instruction = 16'h7ABC; out_ready = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_release: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b1 || dut_bundle !== exp_bundle(16'h7ABC, 1'b1)) begin n_fail++; $display("FAIL rmid_first: got v=%b %h want v=1 %h", out_valid, dut_bundle, exp_bundle(16'h7ABC, 1'b1)); end
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 40 && m_cnt < 17; k++) begin
      instruction = 16'(k * 37);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_tests++; if (z_decode_count !== 4'd1) begin n_fail++; $display("FAIL wrap_cnt4: got %0d want 1", z_decode_count); end
    n_tests++; if (decode_count !== 16'd17) begin n_fail++; $display("FAIL wrap_cnt16: got %0d want 17", decode_count); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      rst         = ($urandom_range(0, 99) == 0);
      flush       = ($urandom_range(0, 24) == 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      instruction = 16'($urandom);
      #1;
      n_tests++;
      if (in_ready !== (!rst && mq.size() < 2) || z_in_ready !== in_ready) begin
        n_fail++; $display("FAIL rand_in_ready[%0d]: got %b/%b want %b", k, in_ready, z_in_ready, !rst && mq.size() < 2);
      end
      n_tests++;
      if (out_valid !== (mq.size() > 0) || z_out_valid !== out_valid) begin
        n_fail++; $display("FAIL rand_out_valid[%0d]: got %b/%b want %b", k, out_valid, z_out_valid, mq.size() > 0);
      end
      if (mq.size() > 0) begin
        n_tests++;
        if (dut_bundle !== exp_bundle(mq[0], 1'b1) || z_bundle !== exp_bundle(mq[0], 1'b0)) begin
          n_fail++; $display("FAIL rand_bundle[%0d]: got %h/%h want %h/%h", k, dut_bundle, z_bundle,
                             exp_bundle(mq[0], 1'b1), exp_bundle(mq[0], 1'b0));
        end
      end
      n_tests++;
      if (decode_count !== m_cnt[15:0] || z_decode_count !== m_cnt[3:0]) begin
        n_fail++; $display("FAIL rand_count[%0d]: got %0d/%0d want %0d/%0d", k, decode_count, z_decode_count, m_cnt[15:0], m_cnt[3:0]);
      end
      tick();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ext_illegal();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_decode_stage.md
Name: inst_decode_stage

Overview:
- Registered, parametrised successor to the combinational instruction decoder. Sits between instruction fetch and warp issue in the compute unit.
- Splits each instruction into fields and adds an extended immediate, a one-hot array select and an illegal-opcode flag.
- Carries results over a valid/ready handshake through a 2-entry skid buffer, so fetch and issue can stall independently without losing an instruction.

Parameters:
- INST_WIDTH, 16, instruction width in bits; minimum 16, MSB-aligned field layout.
- OPCODE_W, 4, opcode field width.
- REG_W, 4, width of the target and address register fields.
- IMM_SHORT_W, 4, short immediate / warp mask width, taken from the instruction LSBs.
- IMM_LONG_W, 8, long immediate width, taken from the instruction LSBs.
- DATA_W, 16, width of the extended immediate; must be at least IMM_LONG_W.
- ARRAY_ID_W, 2, array id width, taken from imm_short MSBs.
- SIGN_EXT_IMM, 1, 1 = sign-extend imm_long, 0 = zero-extend.
- LEGAL_OPCODES, 16'h0FFF, bit n set = opcode n is legal; width is 2**OPCODE_W.
- CNT_W, 16, decoded-instruction counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all buffered instructions
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept an instruction
- instruction  in  INST_WIDTH  raw instruction word
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  issue accepts the bundle
- opcode  out  OPCODE_W  instruction[INST_WIDTH-1 -: OPCODE_W]
- target_reg  out  REG_W  next REG_W bits below opcode
- address_reg  out  REG_W  next REG_W bits below target_reg
- imm_short  out  IMM_SHORT_W  instruction[IMM_SHORT_W-1:0]
- imm_long  out  IMM_LONG_W  instruction[IMM_LONG_W-1:0]
- imm_ext  out  DATA_W  imm_long extended per SIGN_EXT_IMM
- array_id  out  ARRAY_ID_W  imm_short[IMM_SHORT_W-1 -: ARRAY_ID_W]
- array_sel  out  2**ARRAY_ID_W  one-hot decode of array_id
- illegal  out  1  ~LEGAL_OPCODES[opcode]
- decode_count  out  CNT_W  number of bundles accepted by issue

Behaviour:
- Reset, sampled on a clk edge:
  - out_valid=0, all data outputs=0, decode_count=0.
  - Skid entry is cleared.
  - in_ready=0 during every cycle rst is high, and 1 in the first cycle after rst falls.
- Storage is an output register (OR) plus a skid register (SR). Decode logic is combinational on `instruction`; the full decoded bundle is what gets registered.
- in_ready = !SR_valid (registered state, no combinational path from out_ready). A transfer happens when in_valid && in_ready; a transfer happens when out_valid && out_ready.
- Latency: an instruction accepted in cycle N appears on out_valid in cycle N+1, provided OR was empty or was drained in cycle N.
- Full throughput: with in_valid=out_ready=1 held, one bundle per cycle and SR stays empty.
- Stall: if OR holds data, out_ready=0 and an input is accepted, the input goes to SR and in_ready falls in the next cycle.
- When OR drains and SR is valid, SR moves to OR in that same edge and SR empties. A new input cannot arrive in that cycle because in_ready=0.
- Ordering is strictly FIFO. No bundle is ever dropped or duplicated except by flush or reset.
- While out_valid=1 and out_ready=0, the outputs hold stable.
- Flush:
  - On the next edge, OR and SR are invalidated, out_valid=0 and in_ready=1.
  - A same-cycle input transfer is discarded.
  - A same-cycle output transfer still counts in decode_count.
- rst has priority over flush.
- decode_count increments on each output transfer and wraps from 2**CNT_W-1 to 0.
- Illegal opcodes are not blocked: they are delivered with illegal=1 and the issue stage traps.
- Field slicing is purely positional. Bits between address_reg and the immediates are ignored when INST_WIDTH > 16.
- Elaboration must fail if:
  - DATA_W < IMM_LONG_W, or
  - OPCODE_W+2*REG_W > INST_WIDTH, or
  - ARRAY_ID_W > IMM_SHORT_W.

Test Plan:
- Basic decode: instruction=16'h3A5C, in_valid=1, out_ready=1 -> next cycle out_valid=1, opcode=3, target_reg=A, address_reg=5, imm_short=C, imm_long=5C, imm_ext=16'h005C, array_id=3, array_sel=4'b1000, illegal=0.
- Extension and illegal flag: instruction=16'hF2F4 -> imm_ext=16'hFFF4 with SIGN_EXT_IMM=1 and 16'h00F4 with SIGN_EXT_IMM=0; array_id=1, array_sel=4'b0010; illegal=1 (opcode F, default mask).
- Backpressure: stream 16'h1001,16'h1002,16'h1003 with out_ready=0 -> first two accepted, in_ready=0 from the cycle after the second acceptance, third held. Raise out_ready -> imm_long 01,02,03 delivered in order, no gaps, decode_count=3.
- Flush with both entries full, in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1, the flushed instructions never appear, decode_count unchanged.
- Reset mid-stream with OR/SR valid and decode_count=5 -> after the rst edge out_valid=0, in_ready=0 while rst is high, decode_count=0; the first post-reset instruction has latency 1.
- Counter wrap with CNT_W=4: 17 back-to-back transfers -> decode_count reads 1.
